// File: rtl/uart_cmd_initiator.sv
// uart_cmd_initiator
//   Host-side initiator for the 18-byte UART command protocol. It frames
//   {cmd, payload[127:0] MSB-first, cmd} and streams it byte-by-byte to a UART
//   transmitter. It can then collect an 18-byte reply frame from a UART
//   receiver, with an inter-byte timeout.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   cmd_valid/ready     command handshake (ready only while idle)
//   cmd_code            command byte, sent first and last
//   cmd_payload         frame bytes 1..16, MSB first
//   cmd_expect_resp     1 = collect a reply frame after sending
//   tx_data/valid/ready byte stream towards the UART transmitter
//   rx_data/valid       received bytes, one-cycle strobe each
//   resp_data           last complete reply; first byte at [143:136]
//   resp_valid          pulse: resp_data updated
//   resp_timeout        pulse: reply abandoned, resp_data untouched
//   cmd_done            pulse: transaction finished
//   busy                transaction in progress
module uart_cmd_initiator #(
  parameter int FRAME_BYTES    = 18,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [7:0]   cmd_code,
  input  logic [127:0] cmd_payload,
  input  logic         cmd_expect_resp,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [143:0] resp_data,
  output logic         resp_valid,
  output logic         resp_timeout,
  output logic         cmd_done,
  output logic         busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]    LAST_IDX   = 5'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_RESP = 2'd2,
    FINISH    = 2'd3
  } state_t;

  state_t         state_q;
  logic [143:0]   tx_shift_q;   // outgoing frame, current byte on top
  logic [4:0]     idx_q;        // byte index within the outgoing frame
  logic           expect_q;
  logic [135:0]   rx_shift_q;   // first 17 reply bytes; byte 18 comes straight from rx_data
  logic [4:0]     rx_cnt_q;
  logic [TW-1:0]  timer_q;
  logic           end_q;        // reply phase over, enter FINISH next cycle
  logic           cmd_ready_q;
  logic           tx_valid_q;
  logic [143:0]   resp_data_q;
  logic           resp_valid_q;
  logic           resp_timeout_q;
  logic           cmd_done_q;
  logic           busy_q;

  assign cmd_ready    = cmd_ready_q;
  assign tx_data      = tx_shift_q[143:136];
  assign tx_valid     = tx_valid_q;
  assign resp_data    = resp_data_q;
  assign resp_valid   = resp_valid_q;
  assign resp_timeout = resp_timeout_q;
  assign cmd_done     = cmd_done_q;
  assign busy         = busy_q;

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      tx_shift_q     <= 144'h0;
      idx_q          <= 5'd0;
      expect_q       <= 1'b0;
      rx_shift_q     <= 136'h0;
      rx_cnt_q       <= 5'd0;
      timer_q        <= '0;
      end_q          <= 1'b0;
      cmd_ready_q    <= 1'b1;
      tx_valid_q     <= 1'b0;
      resp_data_q    <= 144'h0;
      resp_valid_q   <= 1'b0;
      resp_timeout_q <= 1'b0;
      cmd_done_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      resp_valid_q   <= 1'b0;
      resp_timeout_q <= 1'b0;
      cmd_done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            tx_shift_q  <= {cmd_code, cmd_payload, cmd_code};
            expect_q    <= cmd_expect_resp;
            idx_q       <= 5'd0;
            tx_valid_q  <= 1'b1;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= SEND;
          end
        end
        SEND: begin
          if (tx_ready) begin
            tx_shift_q <= {tx_shift_q[135:0], 8'h00};
            if (idx_q == LAST_IDX) begin
              tx_valid_q <= 1'b0;
              idx_q      <= 5'd0;
              if (expect_q) begin
                rx_cnt_q <= 5'd0;
                timer_q  <= '0;
                end_q    <= 1'b0;
                state_q  <= WAIT_RESP;
              end else begin
                cmd_done_q <= 1'b1;
                state_q    <= FINISH;
              end
            end else begin
              idx_q <= idx_q + 5'd1;
            end
          end
        end
        WAIT_RESP: begin
          if (end_q) begin
            end_q      <= 1'b0;
            cmd_done_q <= 1'b1;
            state_q    <= FINISH;
          end else if (rx_valid) begin
            // A byte on the expiry cycle wins over the timeout.
            rx_shift_q <= {rx_shift_q[127:0], rx_data};
            timer_q    <= '0;
            if (rx_cnt_q == LAST_IDX) begin
              resp_data_q  <= {rx_shift_q, rx_data};
              resp_valid_q <= 1'b1;
              rx_cnt_q     <= 5'd0;
              end_q        <= 1'b1;
            end else begin
              rx_cnt_q <= rx_cnt_q + 5'd1;
            end
          end else if (timer_q == TIMER_LAST) begin
            resp_timeout_q <= 1'b1;
            timer_q        <= '0;
            rx_cnt_q       <= 5'd0;
            end_q          <= 1'b1;
          end else begin
            timer_q <= timer_q + {{(TW-1){1'b0}}, 1'b1};
          end
        end
        FINISH: begin
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          tx_valid_q  <= 1'b0;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          end_q       <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_initiator.sv
// Directed bench for uart_cmd_initiator (TIMEOUT_CYCLES = 50).
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge or 1 unit after a rising edge.
module tb_uart_cmd_initiator;

  localparam int TO = 50;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [7:0]   cmd_code = 8'h00;
  logic [127:0] cmd_payload = 128'h0;
  logic         cmd_expect_resp = 1'b0;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready = 1'b0;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_valid = 1'b0;
  logic [143:0] resp_data;
  logic         resp_valid;
  logic         resp_timeout;
  logic         cmd_done;
  logic         busy;

  uart_cmd_initiator #(.FRAME_BYTES(18), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
    .cmd_payload(cmd_payload), .cmd_expect_resp(cmd_expect_resp),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .resp_data(resp_data), .resp_valid(resp_valid), .resp_timeout(resp_timeout),
    .cmd_done(cmd_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [143:0] got, input logic [143:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor state
  int          cyc = 0;
  logic [7:0]  txq[$];
  int          n_rv = 0;
  int          n_to = 0;
  int          n_done = 0;
  int          done_cyc = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (prev_stall && tx_valid) chk("tx_hold", {136'h0, tx_data}, {136'h0, prev_data});
    prev_stall <= tx_valid && !tx_ready;
    prev_data  <= tx_data;
    if (tx_valid && tx_ready) txq.push_back(tx_data);
    if (resp_valid) n_rv <= n_rv + 1;
    if (resp_timeout) n_to <= n_to + 1;
    if (cmd_done) begin
      n_done   <= n_done + 1;
      done_cyc <= cyc;
    end
  end

  int acc_cyc;

  // Presents a command for one accept edge, then scrambles the inputs.
  task automatic issue(input logic [7:0] code, input logic [127:0] pl, input logic exp_r);
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) break;
      @(posedge clk); #1;
    end
    chk("ready_before_issue", {143'h0, cmd_ready}, {143'h0, 1'b1});
    txq.delete();
    cmd_valid = 1'b1; cmd_code = code; cmd_payload = pl; cmd_expect_resp = exp_r;
    @(posedge clk); #1;
    acc_cyc = cyc;
    cmd_valid = 1'b0; cmd_code = 8'hFF; cmd_payload = {128{1'b1}};
    cmd_expect_resp = ~exp_r;
  endtask

  // Drives tx_ready (mode 0: always, 1: one cycle in three) until 18 bytes
  // have been handed over; optionally injects junk rx bytes meanwhile.
  task automatic send_phase(input int mode, input logic junk);
    int i;
    for (i = 0; i < 300; i++) begin
      if (txq.size() == 18) break;
      tx_ready = (mode == 0) ? 1'b1 : ((i % 3) == 2);
      rx_valid = junk && ((i % 2) == 0);
      rx_data  = 8'hEE;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    chk("send_bound", {143'h0, (i < 300)}, {143'h0, 1'b1});
  endtask

  function automatic logic [143:0] txq_frame();
    logic [143:0] f = 144'h0;
    for (int i = 0; i < txq.size(); i++) f = {f[135:0], txq[i]};
    return f;
  endfunction

  // One rx byte after 'gap' idle edges.
  task automatic rx_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(posedge clk);
    #1;
    rx_valid = 1'b1; rx_data = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_done) break;
    end
    chk(tag, {143'h0, (i < 200)}, {143'h0, 1'b1});
  endtask

  localparam logic [143:0] FRAME_E  = 144'h45_00112233445566778899aabbccddeeff_45;
  localparam logic [143:0] RESP_AT  = 144'h40_0102030405060708090a0b0c0d0e0f10_40;
  localparam logic [7:0]   GAPS [18] = '{8'd0, 8'd3, 8'd1, 8'd49, 8'd0, 8'd7, 8'd2, 8'd48,
                                         8'd5, 8'd0, 8'd1, 8'd49, 8'd0, 8'd4, 8'd9, 8'd1,
                                         8'd0, 8'd30};

  initial begin
    int i;
    int rv0, to0, dn0;
    logic [7:0] b;

    // Reset values
    #12;
    chk("rst_ready", {143'h0, cmd_ready}, {143'h0, 1'b1});
    chk("rst_txv",   {143'h0, tx_valid},  144'h0);
    chk("rst_busy",  {143'h0, busy},      144'h0);
    chk("rst_resp",  resp_data,           144'h0);
    chk("rst_pulses", {141'h0, resp_valid, resp_timeout, cmd_done}, 144'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Send without reply, tx_ready tied high
    issue(8'h45, 128'h00112233445566778899aabbccddeeff, 1'b0);
    chk("busy_after_accept", {143'h0, busy}, {143'h0, 1'b1});
    send_phase(0, 1'b0);
    wait_done("done_noresp");
    chk("ready_in_finish", {143'h0, cmd_ready}, 144'h0);
    @(posedge clk); #1;
    chk("stream_noresp", txq_frame(), FRAME_E);
    chk("stream_len", 144'(txq.size()), 144'd18);
    // accept cycle .. cmd_done cycle inclusive
    chk("latency", 144'(done_cyc - acc_cyc + 2), 144'd20);
    chk("ready_after_done", {143'h0, cmd_ready}, {143'h0, 1'b1});
    chk("no_resp_valid", 144'(n_rv), 144'd0);

    // Backpressure, one accept every three cycles
    issue(8'h45, 128'h00112233445566778899aabbccddeeff, 1'b0);
    send_phase(1, 1'b0);
    wait_done("done_bp");
    chk("stream_bp", txq_frame(), FRAME_E);
    chk("stream_bp_len", 144'(txq.size()), 144'd18);

    // Reply with gaps, including a byte on the exact expiry cycle, and junk during SEND
    rv0 = n_rv; to0 = n_to;
    issue(8'h40, 128'h0f0e0d0c0b0a09080706050403020100, 1'b1);
    send_phase(0, 1'b1);
    for (int k = 0; k < 18; k++) begin
      b = (k == 0 || k == 17) ? 8'h40 : 8'(k);
      rx_byte(b, int'(GAPS[k]));
    end
    chk("resp_valid_pulse", {143'h0, resp_valid}, {143'h0, 1'b1});
    chk("resp_data", resp_data, RESP_AT);
    chk("done_not_with_rv", {143'h0, cmd_done}, 144'h0);
    @(posedge clk); #1;
    chk("rv_one_cycle", {143'h0, resp_valid}, 144'h0);
    chk("done_after_rv", {143'h0, cmd_done}, {143'h0, 1'b1});
    @(posedge clk); #1;
    chk("rv_count", 144'(n_rv - rv0), 144'd1);
    chk("no_timeout_expiry_byte", 144'(n_to - to0), 144'd0);

    // Timeout after 7 bytes
    issue(8'h43, 128'h1, 1'b1);
    send_phase(0, 1'b0);
    for (int k = 0; k < 7; k++) rx_byte(8'hA0 + 8'(k), 2);
    for (i = 1; i <= 70; i++) begin
      @(posedge clk); #1;
      if (resp_timeout) break;
    end
    chk("timeout_delay", 144'(i), 144'd50);
    chk("resp_kept", resp_data, RESP_AT);
    @(posedge clk); #1;
    chk("done_after_to", {143'h0, cmd_done}, {143'h0, 1'b1});
    chk("to_count", 144'(n_to - to0), 144'd1);
    chk("rv_count_to", 144'(n_rv - rv0), 144'd1);

    // New command accepted after the timeout
    issue(8'h45, 128'h00112233445566778899aabbccddeeff, 1'b0);
    send_phase(0, 1'b0);
    wait_done("done_after_to_cmd");
    chk("stream_after_to", txq_frame(), FRAME_E);

    // Reset mid-SEND at byte 5
    issue(8'h45, 128'h00112233445566778899aabbccddeeff, 1'b0);
    tx_ready = 1'b1;
    for (i = 0; i < 50; i++) begin
      if (txq.size() == 5) break;
      @(posedge clk); #1;
    end
    chk("reached_byte5", {143'h0, tx_data == 8'h44}, {143'h0, 1'b1});
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_txv",   {143'h0, tx_valid},  144'h0);
    chk("rst_mid_busy",  {143'h0, busy},      144'h0);
    chk("rst_mid_ready", {143'h0, cmd_ready}, {143'h0, 1'b1});
    dn0 = n_done;
    @(posedge clk); #1;
    rst = 1'b1;
    tx_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("no_done_after_rst", 144'(n_done - dn0), 144'd0);
    chk("idle_after_rst", {143'h0, busy}, 144'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

endmodule
